// File: rtl/axi_lite_cmd_master.sv
// axi_lite_cmd_master: runs one register-level command at a time as an AXI4-Lite
// transaction and returns the slave's response, with a per-channel-state timeout.
module axi_lite_cmd_master #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [DATA_WIDTH-1:0]   cmd_wdata,
   input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic [1:0]              rsp_resp,
   output logic                    rsp_timeout,
   output logic [ADDR_WIDTH-1:0]   write_addr,
   output logic [2:0]              write_prot,
   output logic                    write_addr_valid,
   input  logic                    write_addr_ready,
   output logic [DATA_WIDTH-1:0]   write_data,
   output logic [DATA_WIDTH/8-1:0] write_strb,
   output logic                    write_data_valid,
   input  logic                    write_data_ready,
   output logic                    write_resp_ready,
   input  logic [1:0]              write_resp,
   input  logic                    write_resp_valid,
   output logic [ADDR_WIDTH-1:0]   read_addr,
   output logic [2:0]              read_prot,
   output logic                    read_addr_valid,
   input  logic                    read_addr_ready,
   output logic                    read_data_ready,
   input  logic [DATA_WIDTH-1:0]   read_data,
   input  logic [1:0]              read_resp,
   input  logic                    read_data_valid
);
   localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP} state_t;
   state_t                  state, state_n;
   logic                    alive, aw_done, w_done;
   logic                    aw_hs, w_hs, accept, busy, done, expired, abort;
   logic [CW-1:0]           cnt;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [DATA_WIDTH-1:0]   wdata_q, rdata_q;
   logic [DATA_WIDTH/8-1:0] wstrb_q;
   logic [1:0]              resp_q;
   logic                    timeout_q;
   assign write_addr  = addr_q;
   assign read_addr   = addr_q;
   assign write_data  = wdata_q;
   assign write_strb  = wstrb_q;
   assign write_prot  = 3'b000;
   assign read_prot   = 3'b000;
   assign rsp_rdata   = rdata_q;
   assign rsp_resp    = resp_q;
   assign rsp_timeout = timeout_q;
   // alive keeps cmd_ready low while rst_i is held, even though state is already IDLE
   always_comb begin
      cmd_ready        = (state == IDLE) && alive;
      write_addr_valid = (state == WR_AW_W) && !aw_done;
      write_data_valid = (state == WR_AW_W) && !w_done;
      write_resp_ready = state == WR_B;
      read_addr_valid  = state == RD_AR;
      read_data_ready  = state == RD_R;
      rsp_valid        = state == RSP;
      aw_hs   = write_addr_valid && write_addr_ready;
      w_hs    = write_data_valid && write_data_ready;
      accept  = cmd_valid && cmd_ready;
      busy    = (state == WR_AW_W) || (state == WR_B) || (state == RD_AR) || (state == RD_R);
      done    = (state == WR_AW_W) ? (aw_done || aw_hs) && (w_done || w_hs) :
                (state == WR_B)    ? write_resp_valid :
                (state == RD_AR)   ? read_addr_ready :
                (state == RD_R)    ? read_data_valid : 1'b0;
      expired = (TIMEOUT_CYCLES != 0) && (cnt == CW'(TIMEOUT_CYCLES));
      abort   = busy && !done && expired;
      state_n = state;
      case (state)
         IDLE:    state_n = accept ? (cmd_write ? WR_AW_W : RD_AR) : IDLE;
         WR_AW_W: state_n = done ? WR_B : abort ? RSP : WR_AW_W;
         WR_B:    state_n = (done || abort) ? RSP : WR_B;
         RD_AR:   state_n = done ? RD_R : abort ? RSP : RD_AR;
         RD_R:    state_n = (done || abort) ? RSP : RD_R;
         RSP:     state_n = rsp_ready ? IDLE : RSP;
         default: state_n = IDLE;
      endcase
   end
   // the wait counter restarts on every state change, so it bounds each channel state separately
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= IDLE;
         alive     <= 1'b0;
         cnt       <= '0;
         aw_done   <= 1'b0;
         w_done    <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         rdata_q   <= '0;
         resp_q    <= 2'b00;
         timeout_q <= 1'b0;
      end else begin
         state <= state_n;
         alive <= 1'b1;
         cnt   <= (state_n != state) ? '0 : busy ? cnt + 1'b1 : cnt;
         if (accept) begin
            addr_q  <= cmd_addr;
            wdata_q <= cmd_write ? cmd_wdata : '0;
            wstrb_q <= cmd_write ? cmd_wstrb : '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
         end
         if (aw_hs) aw_done <= 1'b1;
         if (w_hs) w_done <= 1'b1;
         if (abort) begin
            rdata_q   <= '0;
            resp_q    <= 2'b10;
            timeout_q <= 1'b1;
         end else if ((state == WR_B) && done) begin
            rdata_q   <= '0;
            resp_q    <= write_resp;
            timeout_q <= 1'b0;
         end else if ((state == RD_R) && done) begin
            rdata_q   <= read_data;
            resp_q    <= read_resp;
            timeout_q <= 1'b0;
         end
      end
   end
endmodule
